// File: rtl/pipe_stage_hs.sv
// Purpose: valid/ready pipeline stage register with optional 2-entry skid buffer, flush-to-bubble and stall/bubble counters.
// Latency: 1 cycle from accept to out_valid; 1 entry/cycle sustained when out_ready is held high.
// Backpressure: SKID=1 drives in_ready from skid-entry state only (no out_ready path); SKID=0 drives in_ready = !out_valid || out_ready.
module pipe_stage_hs #(
    parameter int unsigned      WIDTH       = 32,
    parameter int unsigned      SKID        = 1,
    parameter int unsigned      CNT_W       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    input  logic             cnt_clear,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    // Main entry M drives the output; skid entry S only ever holds data while M is also live.
    logic             m_vld_q, m_vld_d;
    logic             s_vld_q, s_vld_d;
    logic [WIDTH-1:0] m_dat_q, m_dat_d;
    logic [WIDTH-1:0] s_dat_q, s_dat_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic             accept;
    logic             pop;
    logic             stall_inc;
    logic             bubble_inc;

    // Ready is forced low while reset is held so nothing is offered a handshake that reset will discard.
    always_comb begin
        if (SKID != 0) begin
            in_ready = reset & ~s_vld_q;
        end else begin
            in_ready = reset & (~m_vld_q | out_ready);
        end
    end

    assign accept     = in_valid & in_ready;
    assign pop        = m_vld_q & out_ready;
    assign stall_inc  = m_vld_q & ~out_ready;
    assign bubble_inc = ~m_vld_q;

    assign out_valid  = m_vld_q;
    assign out_data   = m_dat_q;
    assign occupancy  = {1'b0, m_vld_q} + {1'b0, s_vld_q};
    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;

    // Entry movement: flush kills everything (including a same-cycle accept), otherwise FIFO pop/accept.
    always_comb begin
        m_vld_d = m_vld_q;
        m_dat_d = m_dat_q;
        s_vld_d = s_vld_q;
        s_dat_d = s_dat_q;
        if (flush) begin
            m_vld_d = 1'b0;
            m_dat_d = RESET_VALUE;
            s_vld_d = 1'b0;
            s_dat_d = RESET_VALUE;
        end else if (SKID != 0) begin
            // A pop promotes the skid entry (if any) into the head slot.
            if (pop) begin
                m_vld_d = s_vld_q;
                s_vld_d = 1'b0;
                if (s_vld_q) begin
                    m_dat_d = s_dat_q;
                end
            end
            // An accept only happens with S empty; it lands in M if M frees up, else parks in S.
            if (accept) begin
                if (!m_vld_q || pop) begin
                    m_vld_d = 1'b1;
                    m_dat_d = in_data;
                end else begin
                    s_vld_d = 1'b1;
                    s_dat_d = in_data;
                end
            end
        end else begin
            if (accept) begin
                m_vld_d = 1'b1;
                m_dat_d = in_data;
            end else if (pop) begin
                m_vld_d = 1'b0;
            end
        end
    end

    // Saturating performance counters; clear wins over a same-cycle increment.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (cnt_clear) begin
            stall_cnt_d  = '0;
            bubble_cnt_d = '0;
        end else begin
            if (stall_inc && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
            if (bubble_inc && (bubble_cnt_q != {CNT_W{1'b1}})) begin
                bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers with synchronous active-low reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (!reset) begin
            m_vld_q      <= 1'b0;
            m_dat_q      <= RESET_VALUE;
            s_vld_q      <= 1'b0;
            s_dat_q      <= RESET_VALUE;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            m_vld_q      <= m_vld_d;
            m_dat_q      <= m_dat_d;
            s_vld_q      <= s_vld_d;
            s_dat_q      <= s_dat_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Purpose: self-checking bench driving a SKID=0 and a SKID=1 stage with shared stimulus.
// Latency: each step is one clock; outputs checked at the falling edge against a FIFO model.
// Backpressure: each stage's model decides acceptance from its own capacity/ready rule.
module tb_pipe_stage_hs;

    localparam logic [31:0] RV0 = 32'h0000_1234;
    localparam logic [31:0] RV1 = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, flush, in_valid, out_ready, cnt_clear;
    logic [31:0] in_data;

    logic        r0_in_ready, r0_out_valid;
    logic [31:0] r0_out_data;
    logic [1:0]  r0_occ;
    logic [7:0]  r0_stall, r0_bubble;

    logic        r1_in_ready, r1_out_valid;
    logic [31:0] r1_out_data;
    logic [1:0]  r1_occ;
    logic [3:0]  r1_stall, r1_bubble;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model per stage: FIFO contents + count, integer saturating counters.
    int          mcnt   [2];
    logic [31:0] mfifo  [2][2];
    int          mstall [2];
    int          mbub   [2];
    bit          mclean [2];

    pipe_stage_hs #(.WIDTH(32), .SKID(0), .CNT_W(8), .RESET_VALUE(RV0)) u0 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(r0_in_ready), .in_data(in_data),
        .out_valid(r0_out_valid), .out_ready(out_ready), .out_data(r0_out_data),
        .occupancy(r0_occ), .cnt_clear(cnt_clear),
        .stall_cnt(r0_stall), .bubble_cnt(r0_bubble)
    );

    pipe_stage_hs #(.WIDTH(32), .SKID(1), .CNT_W(4), .RESET_VALUE(RV1)) u1 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(r1_in_ready), .in_data(in_data),
        .out_valid(r1_out_valid), .out_ready(out_ready), .out_data(r1_out_data),
        .occupancy(r1_occ), .cnt_clear(cnt_clear),
        .stall_cnt(r1_stall), .bubble_cnt(r1_bubble)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stage k capacity: SKID=1 stage holds 2 and its ready ignores out_ready; SKID=0 holds 1.
    function automatic logic exp_rdy(input int k);
        if (!reset) return 1'b0;
        if (k == 1) return (mcnt[1] < 2);
        return (mcnt[0] == 0) || out_ready;
    endfunction

    task automatic check_dut(input int k, input logic ov, input logic rdy, input logic [31:0] od,
                             input logic [1:0] occ, input logic [63:0] st, input logic [63:0] bu);
        logic [31:0] rv;
        rv = (k == 0) ? RV0 : RV1;
        chk($sformatf("u%0d_out_valid", k), ov, mcnt[k] > 0);
        chk($sformatf("u%0d_in_ready", k), rdy, exp_rdy(k));
        chk($sformatf("u%0d_occupancy", k), occ, 64'(mcnt[k]));
        chk($sformatf("u%0d_stall_cnt", k), st, 64'(mstall[k]));
        chk($sformatf("u%0d_bubble_cnt", k), bu, 64'(mbub[k]));
        if (mcnt[k] > 0) chk($sformatf("u%0d_out_data", k), od, mfifo[k][0]);
        else if (mclean[k]) chk($sformatf("u%0d_out_data_rv", k), od, rv);
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            logic rdy;
            logic ov;
            int   mx;
            rdy = exp_rdy(k);
            ov  = (mcnt[k] > 0);
            mx  = (k == 0) ? 255 : 15;
            if (!reset) begin
                mcnt[k] = 0; mstall[k] = 0; mbub[k] = 0; mclean[k] = 1'b1;
            end else begin
                if (cnt_clear) begin
                    mstall[k] = 0; mbub[k] = 0;
                end else begin
                    if (ov && !out_ready && mstall[k] < mx) mstall[k]++;
                    if (!ov && mbub[k] < mx) mbub[k]++;
                end
                if (flush) begin
                    mcnt[k] = 0; mclean[k] = 1'b1;
                end else begin
                    if (ov && out_ready) begin
                        mfifo[k][0] = mfifo[k][1];
                        mcnt[k]--;
                    end
                    if (in_valid && rdy) begin
                        mfifo[k][mcnt[k]] = in_data;
                        mcnt[k]++;
                        mclean[k] = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_dut(0, r0_out_valid, r0_in_ready, r0_out_data, r0_occ, 64'(r0_stall), 64'(r0_bubble));
        check_dut(1, r1_out_valid, r1_in_ready, r1_out_data, r1_occ, 64'(r1_stall), 64'(r1_bubble));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; cnt_clear = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mcnt[k] = 0; mstall[k] = 0; mbub[k] = 0; mclean[k] = 1'b1;
            mfifo[k][0] = '0; mfifo[k][1] = '0;
        end

        // Reset held for two edges, then stream 1..4 with out_ready high.
        @(posedge clk); #1;
        cycle();
        chk("rst_u1_in_ready", r1_in_ready, 0);
        chk("rst_u0_in_ready", r0_in_ready, 0);
        chk("rst_u1_out_data", r1_out_data, RV1);
        reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("release_u1_in_ready", r1_in_ready, 1);
        chk("release_u0_in_ready", r0_in_ready, 1);
        for (int d = 1; d <= 4; d++) begin
            in_data = d;
            cycle();
            chk("stream_u1_data", r1_out_data, d);
            chk("stream_u0_data", r0_out_data, d);
        end
        in_valid = 1'b0;
        cycle();
        chk("stream_u1_bubble", r1_bubble, 1);
        chk("stream_u0_bubble", r0_bubble, 1);

        // Skid fill with out_ready low, then drain in order.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA; cnt_clear = 1'b1;
        cycle();
        cnt_clear = 1'b0; in_data = 32'hB;
        cycle();
        chk("skid_u1_occ", r1_occ, 2);
        chk("skid_u1_in_ready", r1_in_ready, 0);
        chk("pass_u0_occ", r0_occ, 1);
        chk("pass_u0_in_ready_low", r0_in_ready, 0);
        in_data = 32'hC;
        cycle();
        cycle();
        chk("skid_u1_head", r1_out_data, 32'hA);
        out_ready = 1'b1;
        #1;
        chk("pass_u0_in_ready_comb", r0_in_ready, 1);
        chk("skid_u1_no_comb_ready", r1_in_ready, 0);
        cycle();
        chk("skid_u1_second", r1_out_data, 32'hB);
        chk("pass_u0_swap", r0_out_data, 32'hC);
        cycle();
        chk("skid_u1_third", r1_out_data, 32'hC);
        in_valid = 1'b0;
        cycle();
        chk("skid_u1_drained", r1_out_valid, 0);
        chk("skid_u1_stall", r1_stall, 3);
        chk("skid_u0_stall", r0_stall, 3);

        // Flush while full with a same-cycle offer of 0x55.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'd1;
        cycle();
        in_data = 32'd2;
        cycle();
        chk("flush_pre_u1_occ", r1_occ, 2);
        flush = 1'b1; in_data = 32'h55;
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_u1_valid", r1_out_valid, 0);
        chk("flush_u1_occ", r1_occ, 0);
        chk("flush_u1_data", r1_out_data, RV1);
        chk("flush_u0_valid", r0_out_valid, 0);
        chk("flush_u0_data", r0_out_data, RV0);
        out_ready = 1'b1;
        cycle();
        cycle();
        chk("flush_u1_no_55", r1_out_valid, 0);

        // Bubble counter saturation and clear.
        cnt_clear = 1'b1;
        cycle();
        cnt_clear = 1'b0;
        repeat (20) cycle();
        chk("sat_u1_bubble", r1_bubble, 15);
        chk("sat_u0_bubble", r0_bubble, 20);
        cnt_clear = 1'b1;
        cycle();
        cnt_clear = 1'b0;
        chk("clr_u1_bubble", r1_bubble, 0);
        chk("clr_u0_bubble", r0_bubble, 0);

        // Reset while the skid stage is full.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'd7;
        cycle();
        in_data = 32'd8;
        cycle();
        chk("midrst_pre_u1_occ", r1_occ, 2);
        reset = 1'b0;
        cycle();
        chk("midrst_u1_valid", r1_out_valid, 0);
        chk("midrst_u1_occ", r1_occ, 0);
        chk("midrst_u1_data", r1_out_data, RV1);
        chk("midrst_u1_stall", r1_stall, 0);
        chk("midrst_u1_in_ready", r1_in_ready, 0);
        cycle();
        chk("midrst_u0_in_ready", r0_in_ready, 0);
        reset = 1'b1; in_valid = 1'b0;
        #1;
        chk("midrst_u1_release", r1_in_ready, 1);

        // Randomized traffic checked every cycle against the model.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom();
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            cnt_clear = ($urandom_range(0, 29) == 0);
            reset     = ($urandom_range(0, 49) != 0);
            cycle();
        end
        reset = 1'b1; flush = 1'b0; cnt_clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cycle();
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
